// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, BCD constants and select decoder
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_SUM,
    OP_SR,
    OP_AND,
    OP_EOR,
    OP_OR
  } alu_op_e;

  // A nibble sum above this value is not a valid BCD digit
  localparam logic [4:0] BCD_LIMIT = 5'd9;
  // Added to a nibble to skip the six unused codes A..F
  localparam logic [3:0] BCD_CORR  = 4'd6;

  // Fixed priority: SUMS > SRS > ANDS > EORS > ORS
  function automatic alu_op_e decode_op(input logic sums, input logic srs,
                                        input logic ands, input logic eors,
                                        input logic ors);
    if (sums)      return OP_SUM;
    else if (srs)  return OP_SR;
    else if (ands) return OP_AND;
    else if (eors) return OP_EOR;
    else if (ors)  return OP_OR;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/alu_bcd_adjust.sv
// rtl/alu_bcd_adjust.sv - decimal correction of an 8-bit binary sum
module alu_bcd_adjust
  import alu_pkg::*;
(
  input  logic [7:0] sum_i,
  input  logic       half_carry_i,
  input  logic       carry_i,
  output logic [7:0] sum_o,
  output logic       half_carry_o,
  output logic       carry_o
);

  logic [4:0] lo_sum;
  logic [4:0] hi_sum;
  logic       lo_fix;
  logic       hi_fix;
  logic [3:0] lo_out;
  logic [3:0] hi_out;

  // Rebuild nibble sums from the binary result and correct each digit by +6
  always_comb begin
    lo_sum = {half_carry_i, sum_i[3:0]};
    lo_fix = lo_sum > BCD_LIMIT;
    lo_out = sum_i[3:0] + (lo_fix ? BCD_CORR : 4'd0);
    // Low digit 10..15 carries decimally but not in binary: add that carry here
    hi_sum = {carry_i, sum_i[7:4]} + {4'd0, lo_fix & ~half_carry_i};
    hi_fix = hi_sum > BCD_LIMIT;
    hi_out = hi_sum[3:0] + (hi_fix ? BCD_CORR : 4'd0);
    sum_o        = {hi_out, lo_out};
    half_carry_o = lo_fix;
    carry_o      = hi_fix;
  end

endmodule

// File: rtl/alu_block.sv
// rtl/alu_block.sv - 8-bit registered ALU; define ALU_DECIMAL_EN for decimal add
module alu_block
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_DAA,
  input  logic       sig_CARRY_IN,
  input  logic       sig_SUMS,
  input  logic       sig_ANDS,
  input  logic       sig_EORS,
  input  logic       sig_ORS,
  input  logic       sig_SRS,
  input  logic [7:0] reg_A,
  input  logic [7:0] reg_B,
  output logic       sig_AVR,
  output logic       sig_ACR,
  output logic       sig_HC,
  output logic [7:0] ALU_OUT
);

  alu_op_e    op;
  logic [8:0] bin_sum;
  logic [4:0] lo_sum;
  logic       bin_ovf;
  logic [7:0] bcd_sum;
  logic       bcd_hc;
  logic       bcd_c;

  logic [7:0] alu_out_d, alu_out_q;
  logic       avr_d, avr_q;
  logic       acr_d, acr_q;
  logic       hc_d, hc_q;

  // Decode selects and form the binary sum, its nibble carry and overflow
  always_comb begin
    op      = decode_op(sig_SUMS, sig_SRS, sig_ANDS, sig_EORS, sig_ORS);
    bin_sum = {1'b0, reg_A} + {1'b0, reg_B} + {8'd0, sig_CARRY_IN};
    lo_sum  = {1'b0, reg_A[3:0]} + {1'b0, reg_B[3:0]} + {4'd0, sig_CARRY_IN};
    bin_ovf = (reg_A[7] == reg_B[7]) && (bin_sum[7] != reg_A[7]);
  end

  alu_bcd_adjust u_bcd_adjust (
    .sum_i        (bin_sum[7:0]),
    .half_carry_i (lo_sum[4]),
    .carry_i      (bin_sum[8]),
    .sum_o        (bcd_sum),
    .half_carry_o (bcd_hc),
    .carry_o      (bcd_c)
  );

`ifndef ALU_DECIMAL_EN
  // Binary-only build: decimal enable and corrected sum go nowhere
  logic unused_decimal;
  assign unused_decimal = ^{sig_DAA, bcd_sum, bcd_hc, bcd_c};
`endif

  // Next-state of result and flags; no select keeps the previous values
  always_comb begin
    alu_out_d = alu_out_q;
    avr_d     = avr_q;
    acr_d     = acr_q;
    hc_d      = hc_q;
    case (op)
      OP_SUM: begin
        alu_out_d = bin_sum[7:0];
        avr_d     = bin_ovf;
        acr_d     = bin_sum[8];
        hc_d      = lo_sum[4];
`ifdef ALU_DECIMAL_EN
        if (sig_DAA) begin
          alu_out_d = bcd_sum;
          acr_d     = bcd_c;
          hc_d      = bcd_hc;
        end
`endif
      end
      OP_SR: begin
        alu_out_d = {sig_CARRY_IN, reg_A[7:1]};
        avr_d     = 1'b0;
        acr_d     = reg_A[0];
        hc_d      = 1'b0;
      end
      OP_AND: begin
        alu_out_d = reg_A & reg_B;
        avr_d     = 1'b0;
        acr_d     = 1'b0;
        hc_d      = 1'b0;
      end
      OP_EOR: begin
        alu_out_d = reg_A ^ reg_B;
        avr_d     = 1'b0;
        acr_d     = 1'b0;
        hc_d      = 1'b0;
      end
      OP_OR: begin
        alu_out_d = reg_A | reg_B;
        avr_d     = 1'b0;
        acr_d     = 1'b0;
        hc_d      = 1'b0;
      end
      default: begin
        alu_out_d = alu_out_q;
      end
    endcase
  end

  // Output registers; reset clears result and flags regardless of selects
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= 8'h00;
      avr_q     <= 1'b0;
      acr_q     <= 1'b0;
      hc_q      <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      avr_q     <= avr_d;
      acr_q     <= acr_d;
      hc_q      <= hc_d;
    end
  end

  assign ALU_OUT = alu_out_q;
  assign sig_AVR = avr_q;
  assign sig_ACR = acr_q;
  assign sig_HC  = hc_q;

endmodule

// File: tb/tb_alu_block.sv
// tb/tb_alu_block.sv - randomized self-checking bench for alu_block
module tb_alu_block;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_DAA;
  logic       sig_CARRY_IN;
  logic       sig_SUMS;
  logic       sig_ANDS;
  logic       sig_EORS;
  logic       sig_ORS;
  logic       sig_SRS;
  logic [7:0] reg_A;
  logic [7:0] reg_B;
  logic       sig_AVR;
  logic       sig_ACR;
  logic       sig_HC;
  logic [7:0] ALU_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {AVR, ACR, HC, OUT}
  logic [10:0] exp_state = 11'h0;

  always #5 clk = ~clk;

  alu_block dut (
    .clk          (clk),
    .rst          (rst),
    .sig_DAA      (sig_DAA),
    .sig_CARRY_IN (sig_CARRY_IN),
    .sig_SUMS     (sig_SUMS),
    .sig_ANDS     (sig_ANDS),
    .sig_EORS     (sig_EORS),
    .sig_ORS      (sig_ORS),
    .sig_SRS      (sig_SRS),
    .reg_A        (reg_A),
    .reg_B        (reg_B),
    .sig_AVR      (sig_AVR),
    .sig_ACR      (sig_ACR),
    .sig_HC       (sig_HC),
    .ALU_OUT      (ALU_OUT)
  );

  task automatic check_val(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got {V,C,H,out}=%b,%b,%b,%h expected %b,%b,%b,%h",
               tag, obs[10], obs[9], obs[8], obs[7:0],
               expv[10], expv[9], expv[8], expv[7:0]);
    end
  endtask

  function automatic logic [10:0] observed();
    return {sig_AVR, sig_ACR, sig_HC, ALU_OUT};
  endfunction

  // Reference: evaluates the operation from plain integer arithmetic
  function automatic logic [10:0] ref_next(input logic [10:0] prev);
    int a, b, c, s, res, lo, hi, lc;
    int v, cy, h;
    a = reg_A; b = reg_B; c = sig_CARRY_IN;
    if (rst) return 11'h0;
    if (sig_SUMS) begin
      s   = a + b + c;
      res = s % 256;
      cy  = (s > 255) ? 1 : 0;
      h   = ((a % 16) + (b % 16) + c > 15) ? 1 : 0;
      v   = ((a >= 128) == (b >= 128)) && ((res >= 128) != (a >= 128)) ? 1 : 0;
`ifdef ALU_DECIMAL_EN
      if (sig_DAA) begin
        lo = (a % 16) + (b % 16) + c;
        h  = 0;
        if (lo > 9) begin lo = lo + 6; h = 1; end
        lc = (lo > 15) ? 1 : 0;
        hi = (a / 16) + (b / 16) + lc;
        cy = 0;
        if (hi > 9) begin hi = hi + 6; cy = 1; end
        res = (hi % 16) * 16 + (lo % 16);
      end
`endif
      return {v[0], cy[0], h[0], res[7:0]};
    end
    if (sig_SRS) begin
      res = c * 128 + a / 2;
      cy  = a % 2;
      return {1'b0, cy[0], 1'b0, res[7:0]};
    end
    if (sig_ANDS) return {3'b000, reg_A & reg_B};
    if (sig_EORS) return {3'b000, reg_A ^ reg_B};
    if (sig_ORS)  return {3'b000, reg_A | reg_B};
    return prev;
  endfunction

  // sel = {SUMS, SRS, ANDS, EORS, ORS}
  task automatic step(input string tag, input logic r, input logic [4:0] sel,
                      input logic daa, input logic cin,
                      input logic [7:0] a, input logic [7:0] b);
    rst = r;
    {sig_SUMS, sig_SRS, sig_ANDS, sig_EORS, sig_ORS} = sel;
    sig_DAA = daa; sig_CARRY_IN = cin; reg_A = a; reg_B = b;
    exp_state = ref_next(exp_state);
    @(posedge clk); #1;
    check_val(tag, observed(), exp_state);
  endtask

  localparam logic [4:0] S_SUM = 5'b10000;
  localparam logic [4:0] S_SR  = 5'b01000;
  localparam logic [4:0] S_AND = 5'b00100;
  localparam logic [4:0] S_EOR = 5'b00010;
  localparam logic [4:0] S_OR  = 5'b00001;

  initial begin
    logic [4:0] sel;
    step("reset0", 1'b1, S_SUM, 1'b0, 1'b1, 8'hFF, 8'hFF);
    step("reset1", 1'b1, 5'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check_val("reset_state", observed(), 11'h000);

    step("f0_sum", 1'b0, S_SUM, 1'b0, 1'b0, 8'hF0, 8'h00);
    check_val("f0_sum_k", observed(), {3'b000, 8'hF0});
    step("f0_and", 1'b0, S_AND, 1'b0, 1'b0, 8'hF0, 8'h00);
    check_val("f0_and_k", observed(), {3'b000, 8'h00});
    step("f0_eor", 1'b0, S_EOR, 1'b0, 1'b0, 8'hF0, 8'h00);
    check_val("f0_eor_k", observed(), {3'b000, 8'hF0});
    step("f0_or", 1'b0, S_OR, 1'b0, 1'b0, 8'hF0, 8'h00);
    check_val("f0_or_k", observed(), {3'b000, 8'hF0});
    step("f0_sr", 1'b0, S_SR, 1'b0, 1'b0, 8'hF0, 8'h00);
    check_val("f0_sr_k", observed(), {3'b000, 8'h78});

    step("ab_sum", 1'b0, S_SUM, 1'b0, 1'b0, 8'hAB, 8'hF1);
    check_val("ab_sum_k", observed(), {3'b010, 8'h9C});
    step("ab_and", 1'b0, S_AND, 1'b0, 1'b0, 8'hAB, 8'hF1);
    check_val("ab_and_k", observed(), {3'b000, 8'hA1});
    step("ab_eor", 1'b0, S_EOR, 1'b0, 1'b0, 8'hAB, 8'hF1);
    check_val("ab_eor_k", observed(), {3'b000, 8'h5A});
    step("ab_or", 1'b0, S_OR, 1'b0, 1'b0, 8'hAB, 8'hF1);
    check_val("ab_or_k", observed(), {3'b000, 8'hFB});
    step("ab_sr", 1'b0, S_SR, 1'b0, 1'b0, 8'hAB, 8'hF1);
    check_val("ab_sr_k", observed(), {3'b010, 8'h55});

    step("ovf_sum", 1'b0, S_SUM, 1'b0, 1'b0, 8'h50, 8'h50);
    check_val("ovf_sum_k", observed(), {3'b100, 8'hA0});
    step("sr_cin", 1'b0, S_SR, 1'b0, 1'b1, 8'h7F, 8'h00);
    check_val("sr_cin_k", observed(), {3'b010, 8'hBF});

`ifdef ALU_DECIMAL_EN
    step("dec_19_28", 1'b0, S_SUM, 1'b1, 1'b0, 8'h19, 8'h28);
    check_val("dec_19_28_k", observed(), {3'b001, 8'h47});
    step("dec_99_01", 1'b0, S_SUM, 1'b1, 1'b0, 8'h99, 8'h01);
    check_val("dec_99_01_k", observed(), {3'b011, 8'h00});
`else
    step("bin_19_28", 1'b0, S_SUM, 1'b1, 1'b0, 8'h19, 8'h28);
    check_val("bin_19_28_k", observed(), {3'b001, 8'h41});
`endif
    step("daa_and", 1'b0, S_AND, 1'b1, 1'b0, 8'h19, 8'h28);
    check_val("daa_and_k", observed(), {3'b000, 8'h08});

    step("prio", 1'b0, S_SUM | S_AND, 1'b0, 1'b0, 8'hAB, 8'hF1);
    check_val("prio_k", observed(), {3'b010, 8'h9C});
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 5'b0, 1'b0, 1'b1, 8'h12, 8'h34);
      check_val("hold_k", observed(), {3'b010, 8'h9C});
    end

    step("rst_mid", 1'b1, S_SUM, 1'b0, 1'b1, 8'hFF, 8'hFF);
    check_val("rst_mid_k", observed(), 11'h000);
    step("post_rst", 1'b0, S_SUM, 1'b0, 1'b1, 8'hFF, 8'hFF);
    check_val("post_rst_k", observed(), {3'b011, 8'hFF});

    for (int i = 0; i < 3000; i++) begin
      sel[4] = ($urandom_range(0, 3) == 0);
      sel[3] = ($urandom_range(0, 3) == 0);
      sel[2] = ($urandom_range(0, 3) == 0);
      sel[1] = ($urandom_range(0, 3) == 0);
      sel[0] = ($urandom_range(0, 3) == 0);
      step("random", ($urandom_range(0, 31) == 0), sel,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_block.md
ALU_BLOCK -- requirements
Module: alu_block

Interface
REQ-001 Parameters: none; data width fixed at 8 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sig_DAA  input  1  decimal-adjust enable for addition.
REQ-005 sig_CARRY_IN  input  1  carry in for SUMS; bit-7 fill for SRS.
REQ-006 sig_SUMS  input  1  select add.
REQ-007 sig_ANDS  input  1  select AND.
REQ-008 sig_EORS  input  1  select XOR.
REQ-009 sig_ORS  input  1  select OR.
REQ-010 sig_SRS  input  1  select shift right of reg_A.
REQ-011 reg_A  input  8  operand A.
REQ-012 reg_B  input  8  operand B.
REQ-013 sig_AVR  output  1  registered signed overflow.
REQ-014 sig_ACR  output  1  registered carry out.
REQ-015 sig_HC  output  1  registered half carry (bit 3 to bit 4).
REQ-016 ALU_OUT  output  8  registered result.

Function
REQ-017 All outputs SHALL be registered; a result SHALL appear one clk edge after its operands and select are sampled (latency 1).
REQ-018 Select priority SHALL be SUMS > SRS > ANDS > EORS > ORS when more than one select is high.
REQ-019 With no select high, all outputs SHALL hold their previous values.
REQ-020 SUMS, binary: ALU_OUT = (A+B+Cin)[7:0]; ACR = bit 8; HC = carry out of the low-nibble sum; AVR = (A[7]==B[7]) && (ALU_OUT[7]!=A[7]).
REQ-021 SUMS with sig_DAA=1 (decimal):
- low nibble SHALL be +6 corrected if its sum >9 or carries; HC = 1 in that case.
- high nibble SHALL be +6 corrected if its sum (including the low-nibble carry) >9 or carries; ACR = 1 in that case.
- AVR SHALL be taken from the binary sum.
REQ-022 sig_DAA SHALL be ignored for every operation except SUMS.
REQ-023 ANDS/EORS/ORS: ALU_OUT = A&B, A^B, A|B respectively; AVR, ACR and HC SHALL all be 0.
REQ-024 SRS: ALU_OUT = {Cin, A[7:1]}; ACR = A[0]; AVR = 0; HC = 0; reg_B is unused.
REQ-025 Arithmetic SHALL wrap modulo 256; no saturation.

Reset
REQ-026 When rst=1 at a clk edge, ALU_OUT SHALL be 0x00 and sig_AVR, sig_ACR, sig_HC SHALL be 0, overriding any select.
REQ-027 rst asserted mid-sequence SHALL discard the pending result; the first edge after release SHALL compute normally.

Configuration
REQ-028 Macro ALU_DECIMAL_EN:
- When defined, REQ-021 logic SHALL be compiled in.
- When undefined, sig_DAA SHALL remain a port but be ignored, and SUMS SHALL always be binary.

Structure
REQ-029 Package alu_pkg SHALL hold the operation enum (OP_NONE, OP_SUM, OP_SR, OP_AND, OP_EOR, OP_OR) and the BCD constants (limit 9, correction 6).
REQ-030 The decimal correction SHALL live in one sub-module, alu_bcd_adjust (combinational, 8-bit binary sum plus nibble carries in, corrected byte plus HC/ACR out).

Verification
REQ-031 A=F0, B=00, Cin=0, each op in turn -> SUMS F0 V0 C0; ANDS 00; EORS F0; ORS F0; SRS 78 C0.
REQ-032 A=AB, B=F1, Cin=0 -> SUMS 9C V0 C1 HC0; ANDS A1; EORS 5A; ORS FB; SRS 55 C1.
REQ-033 A=50, B=50, SUMS, Cin=0 -> A0 V1 C0; A=7F, B=00, SRS, Cin=1 -> BF C1.
REQ-034 Decimal (ALU_DECIMAL_EN defined): 19+28, Cin=0 -> 47 HC1 C0; 99+01 -> 00 C1; without the macro, 19+28 -> 41 C0.
REQ-035 SUMS and ANDS both high with A=AB, B=F1 -> 9C (SUMS wins); all selects then dropped -> 9C held for 3 cycles.
REQ-036 rst=1 during SUMS with any operands -> 00, V0 C0 HC0 at the next edge; after release, the next SUMS result appears one edge later.
